// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension pipe: mode encodings and FIFO depth.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO   = 2'd0,
    MODE_SIGN   = 2'd1,
    MODE_UPPER  = 2'd2,
    MODE_SHIFT2 = 2'd3
  } imm_mode_e;

  localparam int FIFO_DEPTH = 2;

endpackage : imm_ext_pkg

// File: rtl/imm_ext_skid.sv
// Two-entry in-order result buffer with valid/ready on both sides.
// in_ready depends only on registered occupancy, so out_ready never reaches it.
module imm_ext_skid
  import imm_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  push, pop;

  assign in_ready  = (count_q < 2'(FIFO_DEPTH));
  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    // push and pop together leave occupancy unchanged
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : imm_ext_skid

// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a 2-entry result buffer; the extended word is what gets stored.
// Define IMM_EXTEND_PIPE_SHIFT2_EN to make mode 11 a sign-extended, left-by-2 branch offset.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = DATA_WIDTH / 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_WIDTH-1:0]   in_imm,
  input  logic [1:0]            in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
);

  localparam int PAD = DATA_WIDTH - IN_WIDTH;

  logic [DATA_WIDTH-1:0] zero_ext, sign_ext, upper_ext, ext_word;

  assign zero_ext  = {{PAD{1'b0}}, in_imm};
  assign sign_ext  = {{PAD{in_imm[IN_WIDTH-1]}}, in_imm};
  assign upper_ext = {in_imm, {PAD{1'b0}}};

  always_comb begin
    ext_word = zero_ext;
    case (imm_mode_e'(in_mode))
      MODE_ZERO:   ext_word = zero_ext;
      MODE_SIGN:   ext_word = sign_ext;
      MODE_UPPER:  ext_word = upper_ext;
`ifdef IMM_EXTEND_PIPE_SHIFT2_EN
      MODE_SHIFT2: ext_word = sign_ext << 2;
`else
      MODE_SHIFT2: ext_word = zero_ext;
`endif
      default:     ext_word = zero_ext;
    endcase
  end

  imm_ext_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (ext_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

endmodule : imm_extend_pipe

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: output word width in bits.
REQ-002 SHALL have parameter IN_WIDTH, default DATA_WIDTH/2: immediate width in bits; legal range 2..DATA_WIDTH-1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an immediate is offered.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an immediate this cycle.
REQ-007 SHALL have port in_imm, input, IN_WIDTH bits: the raw immediate.
REQ-008 SHALL have port in_mode, input, 2 bits: extension mode.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data holds a result.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes out_data this cycle.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: the extended word.

Function
REQ-012 SHALL define a transfer as in_valid & in_ready at a rising edge, and a pop as out_valid & out_ready at a rising edge.
REQ-013 SHALL apply modes as follows: 00 zero-extend; 01 sign-extend from bit IN_WIDTH-1; 10 upper, {in_imm, (DATA_WIDTH-IN_WIDTH) zeros}; 11 per REQ-024.
REQ-014 SHALL compute the extension combinationally at input and store the extended word, not the raw immediate.
REQ-015 SHALL buffer results in a 2-entry in-order FIFO with an occupancy count of 0..2.
REQ-016 SHALL drive in_ready = (count < 2) from registered state only, with no combinational path from out_ready.
REQ-017 SHALL give 1-cycle latency: a transfer at edge N makes out_valid high after edge N when the FIFO was empty.
REQ-018 SHALL drive out_valid = (count != 0), with out_data equal to the head entry.
REQ-019 SHALL, on a simultaneous transfer and pop, leave count unchanged and preserve order.
REQ-020 SHALL hold out_data stable while out_valid & !out_ready.
REQ-021 SHALL ignore in_valid while count == 2, and SHALL ignore out_ready while count == 0; the count SHALL never wrap.

Reset
REQ-022 SHALL, on rst high at an edge, set count=0, out_valid=0, out_data=0 and in_ready=1 after that edge, regardless of other inputs.
REQ-023 SHALL, on reset mid-operation, discard buffered entries, and SHALL NOT accept a transfer presented in the same cycle as rst.

Configuration
REQ-024 SHALL, with macro IMM_EXTEND_PIPE_SHIFT2_EN defined, make mode 11 produce the sign-extended immediate shifted left by 2 (branch offset), with the top two bits discarded; without the macro, mode 11 SHALL behave identically to mode 00.

Structure
REQ-025 SHALL place mode encodings (MODE_ZERO=0, MODE_SIGN=1, MODE_UPPER=2, MODE_SHIFT2=3) and FIFO depth constant 2 in shared package imm_ext_pkg.
REQ-026 SHALL implement storage and count in one sub-module imm_ext_skid, parametrised by DATA_WIDTH, with valid/ready on both sides; the extension logic stays in the top level.

Verification
REQ-027 SHALL test that mode 00 with in_imm=16'h8001 and the FIFO empty gives out_data=32'h00008001 with out_valid high one cycle after the transfer.
REQ-028 SHALL test that mode 01 with in_imm=16'hFFFE gives out_data=32'hFFFFFFFE, and that mode 10 with 16'h1234 gives 32'h12340000.
REQ-029 SHALL test that mode 11 with in_imm=16'hFFFF gives 32'hFFFFFFFC when IMM_EXTEND_PIPE_SHIFT2_EN is defined, and 32'h0000FFFF when it is not.
REQ-030 SHALL test backpressure: with out_ready=0, pushing A=1, B=2, C=3 on consecutive cycles makes in_ready low after B and drops C; then out_ready=1 pops A, then B, and count returns to 0.
REQ-031 SHALL test that with count=1 and simultaneous transfer and pop for 10 cycles, count stays 1 and outputs appear in input order with no loss.
REQ-032 SHALL test reset: rst asserted with count=2 and in_valid=1 gives out_valid=0, out_data=0 and in_ready=1 next cycle, and no entry is retained.
